// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pkg
//  Purpose  : Shared Hamming(12,8) constants, receiver state type and the
//             syndrome helper used by the encoder/decoder family.
//  Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    localparam int HAM_N = 12;
    localparam int HAM_K = 8;
    localparam int HAM_P = 4;

    // Hamming positions (1-based), packed 4 bits per entry, entry 0 in the LSBs
    localparam logic [HAM_P*4-1:0] c_PARITY_POS = {4'd8, 4'd4, 4'd2, 4'd1};
    localparam logic [HAM_K*4-1:0] c_DATA_POS   = {4'd12, 4'd11, 4'd10, 4'd9,
                                                   4'd7,  4'd6,  4'd5,  4'd3};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } rx_state_e;

    function automatic logic [3:0] ham_syndrome(input logic [HAM_N-1:0] word);
        logic [3:0] s;
        s = '0;
        for (int j = 0; j < HAM_N; j++) begin
            if (word[j]) s = s ^ 4'(j + 1);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_correct.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_correct
//  Purpose  : Combinational syndrome check, single-bit correction and data
//             extraction for one Hamming(12,8) codeword.
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_correct
    import hamming_pkg::*;
(
    input  logic [HAM_N-1:0] i_word,
    output logic [HAM_K-1:0] o_data,
    output logic [3:0]       o_syndrome,
    output logic             o_corrected,
    output logic             o_uncorrectable
);

    logic [3:0]       w_syn;
    logic [HAM_N-1:0] w_fixed;

    always_comb begin
        w_syn           = ham_syndrome(i_word);
        w_fixed         = i_word;
        o_corrected     = (w_syn != 4'd0) && (w_syn <= 4'(HAM_N));
        o_uncorrectable = (w_syn > 4'(HAM_N));
        // Syndromes past the last position cannot name a bit: data passes raw
        if (o_corrected) w_fixed[w_syn - 4'd1] = ~i_word[w_syn - 4'd1];
        o_data = '0;
        for (int i = 0; i < HAM_K; i++) begin
            o_data[i] = w_fixed[c_DATA_POS[i*4 +: 4] - 4'd1];
        end
        o_syndrome = w_syn;
    end

endmodule
`default_nettype wire

// File: rtl/hamming_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_serial_rx
//  Purpose  : Bit-serial Hamming(12,8) receiver with correction, one-entry
//             valid/ready output holding register and saturating counters.
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_serial_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    output logic [HAM_K-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             err_corrected,
    output logic             err_uncorrectable,
    output logic [3:0]       syndrome,
    output logic             overrun,
    output logic [CNT_W-1:0] corr_count,
    output logic [CNT_W-1:0] uncorr_count
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rx_state_e        r_state_q, w_state_d;
    logic [HAM_N-1:0] r_shift_q, w_shift_d;
    logic [3:0]       r_cnt_q, w_cnt_d;
    logic [HAM_K-1:0] r_dout_q, w_dout_d;
    logic             r_valid_q, w_valid_d;
    logic             r_corr_flag_q, w_corr_flag_d;
    logic             r_uncorr_flag_q, w_uncorr_flag_d;
    logic [3:0]       r_syn_q, w_syn_d;
    logic             r_overrun_q, w_overrun_d;
    logic [CNT_W-1:0] r_corr_cnt_q, w_corr_cnt_d;
    logic [CNT_W-1:0] r_uncorr_cnt_q, w_uncorr_cnt_d;

    logic [HAM_K-1:0] w_data;
    logic [3:0]       w_syn;
    logic             w_corr;
    logic             w_uncorr;

    hamming_correct u_correct (
        .i_word          (r_shift_q),
        .o_data          (w_data),
        .o_syndrome      (w_syn),
        .o_corrected     (w_corr),
        .o_uncorrectable (w_uncorr)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_shift_d       = r_shift_q;
        w_cnt_d         = r_cnt_q;
        w_dout_d        = r_dout_q;
        w_valid_d       = r_valid_q;
        w_corr_flag_d   = r_corr_flag_q;
        w_uncorr_flag_d = r_uncorr_flag_q;
        w_syn_d         = r_syn_q;
        w_overrun_d     = r_overrun_q;
        w_corr_cnt_d    = r_corr_cnt_q;
        w_uncorr_cnt_d  = r_uncorr_cnt_q;

        if (r_valid_q && dout_ready) w_valid_d = 1'b0;

        unique case (r_state_q)
            ST_IDLE: begin
                if (sin_valid && frame_start) begin
                    w_shift_d = {{(HAM_N-1){1'b0}}, sin};
                    w_cnt_d   = 4'd1;
                    w_state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sin_valid) begin
                    // A fresh frame_start abandons the partial word silently
                    if (frame_start) begin
                        w_shift_d = {{(HAM_N-1){1'b0}}, sin};
                        w_cnt_d   = 4'd1;
                    end else begin
                        w_shift_d[r_cnt_q] = sin;
                        w_cnt_d            = r_cnt_q + 4'd1;
                        if (r_cnt_q == 4'(HAM_N - 1)) w_state_d = ST_DECODE;
                    end
                end
            end
            ST_DECODE: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = 4'd0;
                if (!r_valid_q || dout_ready) begin
                    w_dout_d        = w_data;
                    w_valid_d       = 1'b1;
                    w_corr_flag_d   = w_corr;
                    w_uncorr_flag_d = w_uncorr;
                    w_syn_d         = w_syn;
                end else begin
                    w_overrun_d = 1'b1;
                end
                // Statistics count every decoded word, including dropped ones
                if (w_corr && !(&r_corr_cnt_q))
                    w_corr_cnt_d = r_corr_cnt_q + c_CNT_ONE;
                if (w_uncorr && !(&r_uncorr_cnt_q))
                    w_uncorr_cnt_d = r_uncorr_cnt_q + c_CNT_ONE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= ST_IDLE;
            r_shift_q       <= '0;
            r_cnt_q         <= '0;
            r_dout_q        <= '0;
            r_valid_q       <= 1'b0;
            r_corr_flag_q   <= 1'b0;
            r_uncorr_flag_q <= 1'b0;
            r_syn_q         <= '0;
            r_overrun_q     <= 1'b0;
            r_corr_cnt_q    <= '0;
            r_uncorr_cnt_q  <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_shift_q       <= w_shift_d;
            r_cnt_q         <= w_cnt_d;
            r_dout_q        <= w_dout_d;
            r_valid_q       <= w_valid_d;
            r_corr_flag_q   <= w_corr_flag_d;
            r_uncorr_flag_q <= w_uncorr_flag_d;
            r_syn_q         <= w_syn_d;
            r_overrun_q     <= w_overrun_d;
            r_corr_cnt_q    <= w_corr_cnt_d;
            r_uncorr_cnt_q  <= w_uncorr_cnt_d;
        end
    end

    assign dout              = r_dout_q;
    assign dout_valid        = r_valid_q;
    assign err_corrected     = r_corr_flag_q;
    assign err_uncorrectable = r_uncorr_flag_q;
    assign syndrome          = r_syn_q;
    assign overrun           = r_overrun_q;
    assign corr_count        = r_corr_cnt_q;
    assign uncorr_count      = r_uncorr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_serial_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_hamming_serial_rx
//  Purpose  : Self-checking bench for hamming_serial_rx against a word-level
//             reference model; second instance with 2-bit counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_serial_rx;

    localparam int CNT_W   = 16;
    localparam int SMALL_W = 2;

    logic clk = 1'b0;
    logic rst, sin, sin_valid, frame_start, dout_ready;

    logic [7:0]         dout;
    logic               dout_valid, err_corrected, err_uncorrectable, overrun;
    logic [3:0]         syndrome;
    logic [CNT_W-1:0]   corr_count, uncorr_count;

    logic [7:0]         s_dout;
    logic               s_valid, s_corr, s_uncorr, s_overrun;
    logic [3:0]         s_syn;
    logic [SMALL_W-1:0] s_corr_cnt, s_uncorr_cnt;

    hamming_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .err_corrected(err_corrected),
        .err_uncorrectable(err_uncorrectable), .syndrome(syndrome),
        .overrun(overrun), .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    hamming_serial_rx #(.CNT_W(SMALL_W)) dut_small (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .frame_start(frame_start), .dout(s_dout), .dout_valid(s_valid),
        .dout_ready(dout_ready), .err_corrected(s_corr),
        .err_uncorrectable(s_uncorr), .syndrome(s_syn),
        .overrun(s_overrun), .corr_count(s_corr_cnt), .uncorr_count(s_uncorr_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit rand_ready = 0;
    bit junk       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int data_pos(input int i);
        int dp[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
        return dp[i];
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] b);
        logic [11:0] w;
        bit par;
        w = '0;
        for (int i = 0; i < 8; i++) w[data_pos(i) - 1] = b[i];
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if ((pos & p) != 0 && pos != p) par = par ^ w[pos - 1];
            w[p - 1] = par;
        end
        return w;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // ---------------- reference model (word level) ----------------
    bit          m_bits[$];
    bit          m_in_word, m_pending;
    logic [11:0] m_word;
    bit          exp_valid, exp_corr, exp_uncorr, exp_overrun;
    logic [7:0]  exp_dout;
    logic [3:0]  exp_syn;
    int          exp_corr_cnt, exp_uncorr_cnt;
    int          r_syn;
    logic [11:0] r_fix;
    logic [7:0]  r_data;

    always @(posedge clk) begin
        if (rst) begin
            m_bits.delete();
            m_in_word = 0; m_pending = 0;
            exp_valid = 0; exp_dout = '0; exp_syn = '0; exp_corr = 0;
            exp_uncorr = 0; exp_overrun = 0; exp_corr_cnt = 0; exp_uncorr_cnt = 0;
        end else if (m_pending) begin
            r_syn = 0;
            for (int pos = 1; pos <= 12; pos++) if (m_word[pos - 1]) r_syn = r_syn ^ pos;
            r_fix = m_word;
            if (r_syn >= 1 && r_syn <= 12) r_fix[r_syn - 1] = ~r_fix[r_syn - 1];
            for (int i = 0; i < 8; i++) r_data[i] = r_fix[data_pos(i) - 1];
            if (!exp_valid || dout_ready) begin
                exp_valid  = 1;
                exp_dout   = r_data;
                exp_syn    = 4'(r_syn);
                exp_corr   = (r_syn >= 1 && r_syn <= 12);
                exp_uncorr = (r_syn >= 13);
            end else begin
                exp_overrun = 1;
            end
            if (r_syn >= 1 && r_syn <= 12) exp_corr_cnt++;
            if (r_syn >= 13) exp_uncorr_cnt++;
            m_pending = 0;
        end else begin
            if (exp_valid && dout_ready) exp_valid = 0;
            if (sin_valid) begin
                if (frame_start) begin
                    m_bits.delete();
                    m_bits.push_back(sin);
                    m_in_word = 1;
                end else if (m_in_word) begin
                    m_bits.push_back(sin);
                end
                if (m_in_word && m_bits.size() == 12) begin
                    for (int i = 0; i < 12; i++) m_word[i] = m_bits[i];
                    m_pending = 1;
                    m_in_word = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("dout", 32'(dout), 32'(exp_dout));
            chk("syndrome", 32'(syndrome), 32'(exp_syn));
            chk("err_corrected", 32'(err_corrected), 32'(exp_corr));
            chk("err_uncorrectable", 32'(err_uncorrectable), 32'(exp_uncorr));
        end
        chk("overrun", 32'(overrun), 32'(exp_overrun));
        chk("corr_count", 32'(corr_count), 32'(sat(exp_corr_cnt, CNT_W)));
        chk("uncorr_count", 32'(uncorr_count), 32'(sat(exp_uncorr_cnt, CNT_W)));
        chk("small_corr_count", 32'(s_corr_cnt), 32'(sat(exp_corr_cnt, SMALL_W)));
        chk("small_uncorr_count", 32'(s_uncorr_cnt), 32'(sat(exp_uncorr_cnt, SMALL_W)));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_bits(input logic [11:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            sin_valid = 1'b1; sin = w[i]; frame_start = (i == 0);
        end
    endtask

    task automatic send_word(input logic [11:0] w);
        drive_bits(w, 12);
        tick();
        frame_start = 1'b0; sin_valid = 1'b0;
        if (junk) begin
            sin_valid = 1'($urandom); sin = 1'($urandom); frame_start = 1'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(); sin_valid = 1'b0; frame_start = 1'b0;
        end
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; sin_valid = 1'b0; frame_start = 1'b0;
        tick(); rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'h0);
        chk({tag, "_valid"}, 32'(dout_valid), 32'h0);
        chk({tag, "_flags"}, 32'({err_corrected, err_uncorrectable, overrun}), 32'h0);
        chk({tag, "_syn"}, 32'(syndrome), 32'h0);
        chk({tag, "_cnts"}, 32'({corr_count, uncorr_count}), 32'h0);
    endtask

    initial begin
        logic [11:0] w;
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; frame_start = 1'b0; dout_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_reset_vals("reset");
        chk("encode_A5", 32'(encode(8'hA5)), 32'hA27);

        // clean, single-error and uncorrectable words
        send_word(12'hA27);
        @(posedge clk); #1;
        chk("clean_dout", 32'(dout), 32'hA5);
        chk("clean_syn_flags", 32'({syndrome, err_corrected, err_uncorrectable}), 32'h0);
        chk("clean_cnts", 32'({corr_count, uncorr_count}), 32'h0);
        send_word(12'hA67);
        @(posedge clk); #1;
        chk("single_dout", 32'(dout), 32'hA5);
        chk("single_syn", 32'(syndrome), 32'd7);
        chk("single_flag", 32'(err_corrected), 32'h1);
        chk("single_cnt", 32'(corr_count), 32'd1);
        send_word(12'h226);
        @(posedge clk); #1;
        chk("uncorr_dout", 32'(dout), 32'h25);
        chk("uncorr_syn", 32'(syndrome), 32'd13);
        chk("uncorr_flag", 32'(err_uncorrectable), 32'h1);
        chk("uncorr_cnt", 32'(uncorr_count), 32'd1);

        // backpressure and overrun
        idle(2);
        dout_ready = 1'b0;
        send_word(encode(8'h11));
        send_word(encode(8'h22));
        @(posedge clk); #1;
        chk("bp_dout", 32'(dout), 32'h11);
        chk("bp_valid", 32'(dout_valid), 32'h1);
        chk("bp_overrun", 32'(overrun), 32'h1);
        idle(4);
        chk("bp_hold_dout", 32'(dout), 32'h11);
        tick(); dout_ready = 1'b1;
        tick();
        chk("bp_one_xfer", 32'(dout_valid), 32'h0);
        idle(3);
        chk("bp_no_second", 32'(dout_valid), 32'h0);
        chk("bp_sticky", 32'(overrun), 32'h1);

        // reset while a word is held
        dout_ready = 1'b0;
        send_word(encode(8'h77));
        idle(2);
        do_reset();
        chk_reset_vals("rst_hold");
        dout_ready = 1'b1;

        // abort at bit 5, then a full word
        w = encode(8'h99);
        drive_bits(w, 5);
        send_word(encode(8'h3C));
        @(posedge clk); #1;
        chk("abort_dout", 32'(dout), 32'h3C);
        chk("abort_valid", 32'(dout_valid), 32'h1);

        // reset mid-word; trailing bits without frame_start are ignored
        w = encode(8'h5A);
        drive_bits(w, 6);
        do_reset();
        chk_reset_vals("rst_word");
        for (int i = 6; i < 12; i++) begin
            tick(); sin_valid = 1'b1; sin = w[i]; frame_start = 1'b0;
        end
        idle(4);
        chk("rst_word_no_emit", 32'(dout_valid), 32'h0);

        // exhaustive: every byte, clean and each single-bit error
        do_reset();
        for (int b = 0; b < 256; b++) begin
            for (int e = -1; e < 12; e++) begin
                w = encode(8'(b));
                if (e >= 0) w[e] = ~w[e];
                send_word(w);
                @(posedge clk); #1;
                chk("exh_dout", 32'(dout), 32'(b));
            end
        end
        idle(2);
        chk("exh_corr_count", 32'(corr_count), 32'd3072);
        chk("exh_small_sat", 32'(s_corr_cnt), 32'd3);

        // randomized traffic: errors, aborts, junk strobes, random ready
        rand_ready = 1; junk = 1;
        for (int n = 0; n < 300; n++) begin
            w = encode(8'($urandom));
            case ($urandom_range(0, 3))
                1: w[$urandom_range(0, 11)] ^= 1'b1;
                2: w = w ^ (12'h001 << $urandom_range(0, 5)) ^ (12'h040 << $urandom_range(0, 5));
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) drive_bits(12'($urandom), $urandom_range(1, 11));
            send_word(w);
            idle($urandom_range(0, 2));
        end
        rand_ready = 0; junk = 0;
        dout_ready = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hamming_serial_rx.md
# hamming_serial_rx

Bit-serial receive end for Hamming(12,8) codewords produced by `hamming_encoder`. The block is sequential and does the following:
- Deserialises a framed serial stream into 12-bit codewords.
- Computes the syndrome and corrects single-bit errors.
- Presents the recovered byte on a valid/ready output port.
- Keeps saturating counters of corrected and uncorrectable words.

It sits between the serial link PHY and byte-wide consumers.

## Interface
- `CNT_W`, 16: width of each error counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial data bit; sampled only when `sin_valid`=1.
- `sin_valid`  in  1  bit strobe.
- `frame_start`  in  1  qualifies the strobed bit as codeword bit 0; ignored unless `sin_valid`=1.
- `dout`  out  8  decoded and corrected byte.
- `dout_valid`  out  1  `dout`/flags hold a word.
- `dout_ready`  in  1  consumer accepts when `dout_valid`&`dout_ready`.
- `err_corrected`  out  1  word had a nonzero syndrome in 1..12 and was corrected.
- `err_uncorrectable`  out  1  syndrome in 13..15; `dout` is raw uncorrected data.
- `syndrome`  out  4  syndrome of the held word.
- `overrun`  out  1  sticky; set when a completed word is dropped; cleared only by `rst`.
- `corr_count`  out  `CNT_W`  corrected words, saturating at all-ones.
- `uncorr_count`  out  `CNT_W`  uncorrectable words, saturating.

## Operation
- Codeword layout:
  - Bit index j holds Hamming position j+1.
  - Parity bits are at positions 1, 2, 4, 8.
  - Data d0..d7 are at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - This matches `hamming_encoder`.
- Serial order is LSB first: bit 0 (position 1) is received first.
- FSM states:
  - IDLE: in IDLE, `sin_valid` without `frame_start` is ignored. With `frame_start`, the block stores the bit, sets bit count to 1 and goes to SHIFT.
  - SHIFT: each strobed bit is stored at index = count and the count is incremented. After the 12th bit the block goes to DECODE.
  - DECODE: one cycle. The block computes the syndrome (XOR of positions of all set bits) and applies correction, then returns to IDLE.
- `frame_start` with `sin_valid` in SHIFT aborts the partial word. That bit becomes bit 0 of a new word, count=1. Nothing is emitted and no counter moves.
- Syndrome results:
  - 0: no error.
  - 1..12: flip that position, set `err_corrected`, increment `corr_count`.
  - 13..15: no flip, set `err_uncorrectable`, increment `uncorr_count`.
- Output is a one-entry holding register:
  - In DECODE, if the register is empty, or is being consumed in the same cycle, load `dout`/flags/`syndrome` and set `dout_valid`.
  - Otherwise drop the new word and set `overrun`.
  - Counters still update for the dropped word.
- `dout_valid` stays high, with all output fields stable, until the handshake completes.
- Bits strobed while in DECODE are ignored. The sender must leave ≥1 idle cycle between words.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `err_corrected`=0, `err_uncorrectable`=0, `syndrome`=0, `overrun`=0, both counters 0. FSM goes to IDLE, bit count 0.
- Reset mid-word or mid-hold discards all state. No output is emitted.
- Latency: 12th bit sampled at edge N, DECODE during cycle N→N+1, `dout_valid`=1 after edge N+1.
- Handshake:
  - `dout_valid` falls after the accepting edge unless a new word loads on that same edge.
  - On simultaneous accept and load, `dout_valid` stays 1 with the new data.
- Counters saturate: at all-ones an increment has no effect.

## Structure
- Package `hamming_pkg` holds the following, shared with `hamming_encoder`/`hamming_decoder`:
  - Constants `HAM_N`=12, `HAM_K`=8.
  - Parity-position and data-position constants.
  - A function computing the 4-bit syndrome.
- Sub-module `hamming_correct` is combinational. It takes a 12-bit word and produces corrected byte, syndrome, corrected flag and uncorrectable flag. It is instantiated once in DECODE.

## Test plan
- Clean word: send 0xA5, encoded 0xA27, LSB first, with `dout_ready`=1. Required: after edge N+1, `dout`=0xA5, `syndrome`=0, no flags, counters 0.
- Single error: send 0xA67 (bit 6 flipped). Required: `dout`=0xA5, `syndrome`=7, `err_corrected`=1, `corr_count`=1.
- Uncorrectable: send 0x226 (positions 1 and 12 flipped). Required: `syndrome`=13, `err_uncorrectable`=1, `dout`=0x25, `uncorr_count`=1.
- Backpressure and overrun:
  - Hold `dout_ready`=0 and send two words.
  - Required: first word held stable, second dropped, `overrun`=1 sticky.
  - Raising `dout_ready` yields exactly one transfer.
- Abort and reset: assert `frame_start` at bit 5 of a word, then send a full 0x3C word. Required: only 0x3C emitted. `rst` asserted mid-word: all outputs return to reset values and the partial word is never emitted.
- Exhaustive: all 256 bytes × {no error, each of 12 single-bit errors} streamed back-to-back with one idle cycle between words. Required: `dout` equals the input byte every time and `corr_count`=3072.
